// File: rtl/dff_arb_pkg.sv
// Shared definitions for the two-requester register arbiter: state encoding,
// requester IDs, default width and the tie-break helper.
package dff_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // With rr set, a tie goes to whoever was not served last; otherwise A always wins.
    function automatic logic pick_winner(input logic req_a, input logic req_b,
                                         input logic last, input logic rr);
        logic winner;
        if (req_a && req_b) begin
            winner = rr ? ~last : ID_A;
        end else if (req_a) begin
            winner = ID_A;
        end else begin
            winner = ID_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/dff_load_register.sv
// WIDTH-bit D-register with synchronous active-high reset and load enable.
module dff_load_register
    import dff_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dff_register_arbiter.sv
// Arbitrates two requesters onto one shared register via a Moore FSM.
// Define ROUND_ROBIN_EN for alternating tie-breaks; default is fixed priority to A.
module dff_register_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] D_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] D_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             ACK_A,
    output logic             ACK_B,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY
);

`ifdef ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic             own_q, own_d;
    logic             last_q, last_d;
    logic             req_own;
    logic [WIDTH-1:0] d_own;
    logic             load;
    logic             owns;

    assign req_own = (own_q == ID_B) ? REQ_B : REQ_A;
    assign d_own   = (own_q == ID_B) ? D_B : D_A;
    assign load    = (state_q == ST_GRANT) && req_own;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            own_q   <= ID_A;
            last_q  <= ID_B;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_A || REQ_B) begin
                    own_d   = pick_winner(REQ_A, REQ_B, last_q, RR_EN);
                    state_d = ST_GRANT;
                end
            end
            // A withdrawn request aborts without writing or touching LAST.
            ST_GRANT:   state_d = req_own ? ST_ACK : ST_IDLE;
            ST_ACK: begin
                last_d  = own_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!req_own) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    assign owns  = (state_q == ST_GRANT) || (state_q == ST_ACK);
    assign GNT_A = owns && (own_q == ID_A);
    assign GNT_B = owns && (own_q == ID_B);
    assign ACK_A = (state_q == ST_ACK) && (own_q == ID_A);
    assign ACK_B = (state_q == ST_ACK) && (own_q == ID_B);
    assign BUSY  = (state_q != ST_IDLE);

    dff_load_register #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk  (CLK),
        .rst  (RST),
        .load (load),
        .d    (d_own),
        .q    (Q)
    );

endmodule

// File: tb/tb_dff_register_arbiter.sv
// Scoreboard bench for dff_register_arbiter: expected writes are queued at stimulus
// time and a negedge monitor checks each ACK against the queue head.
module tb_dff_register_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_A, REQ_B;
    logic [7:0] D_A, D_B;
    logic       GNT_A, GNT_B, ACK_A, ACK_B, BUSY;
    logic [7:0] Q;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

`ifdef ROUND_ROBIN_EN
    localparam logic [7:0] Q_AFTER_T3 = 8'h22;
`else
    localparam logic [7:0] Q_AFTER_T3 = 8'h11;
`endif

    dff_register_arbiter #(
        .WIDTH (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ_A (REQ_A),
        .D_A   (D_A),
        .REQ_B (REQ_B),
        .D_B   (D_B),
        .GNT_A (GNT_A),
        .GNT_B (GNT_B),
        .ACK_A (ACK_A),
        .ACK_B (ACK_B),
        .Q     (Q),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits at negedges for a condition; sel 0=ACK_A 1=ACK_B 2=idle 3=GNT_B 4=any ACK.
    task automatic wait_for(input int sel, input string name);
        bit hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge CLK);
            case (sel)
                0: hit = ACK_A;
                1: hit = ACK_B;
                2: hit = !BUSY;
                3: hit = GNT_B;
                default: hit = ACK_A || ACK_B;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout %s: condition not seen within 30 cycles", name);
        end
    endtask

    // Monitor: every ACK must match the oldest queued write; grants must be exclusive.
    always @(negedge CLK) begin
        if (GNT_A || GNT_B) begin
            check("gnt_exclusive", {31'd0, GNT_A && GNT_B}, 32'd0);
        end
        if (ACK_A && ACK_B) begin
            check("ack_exclusive", 32'd1, 32'd0);
        end else if (ACK_A || ACK_B) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'd0, ACK_B}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_id", {31'd0, ACK_B}, {31'd0, e.id});
                check("ack_q", {24'd0, Q}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset held two cycles while A requests: nothing may be written.
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b0; D_A = 8'h77; D_B = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("rst_q", {24'd0, Q}, 32'h00);
            check("rst_gnt", {30'd0, GNT_A, GNT_B}, 32'd0);
            check("rst_ack", {30'd0, ACK_A, ACK_B}, 32'd0);
            check("rst_busy", {31'd0, BUSY}, 32'd0);
        end
        RST = 1'b0; REQ_A = 1'b0;
        @(negedge CLK);

        // 2. Single write from A with cycle-accurate latency checks.
        REQ_A = 1'b1; D_A = 8'hA5;
        sb.push_back('{id: 1'b0, data: 8'hA5});
        @(negedge CLK);
        check("t2_gnt_a", {31'd0, GNT_A}, 32'd1);
        check("t2_ack_early", {31'd0, ACK_A}, 32'd0);
        check("t2_q_hold", {24'd0, Q}, 32'h00);
        check("t2_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("t2_ack_a", {31'd0, ACK_A}, 32'd1);
        check("t2_gnt_in_ack", {31'd0, GNT_A}, 32'd1);
        REQ_A = 1'b0;
        @(negedge CLK);
        check("t2_release_gnt", {31'd0, GNT_A}, 32'd0);
        check("t2_ack_once", {31'd0, ACK_A}, 32'd0);
        check("t2_release_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("t2_idle_busy", {31'd0, BUSY}, 32'd0);
        check("t2_q_kept", {24'd0, Q}, 32'hA5);

        // Reset so LAST returns to B before contention.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // 3. Continuous contention: each requester drops only until the FSM is idle.
        D_A = 8'h11; D_B = 8'h22;
`ifdef ROUND_ROBIN_EN
        sb.push_back('{id: 1'b0, data: 8'h11});
        sb.push_back('{id: 1'b1, data: 8'h22});
        sb.push_back('{id: 1'b0, data: 8'h11});
        sb.push_back('{id: 1'b1, data: 8'h22});
`else
        for (int i = 0; i < 4; i++) sb.push_back('{id: 1'b0, data: 8'h11});
`endif
        REQ_A = 1'b1; REQ_B = 1'b1;
        for (int n = 0; n < 4; n++) begin
            logic was_b;
            wait_for(4, "t3_ack");
            was_b = ACK_B;
            if (n == 3) begin
                REQ_A = 1'b0; REQ_B = 1'b0;
            end else if (was_b) begin
                REQ_B = 1'b0;
            end else begin
                REQ_A = 1'b0;
            end
            wait_for(2, "t3_idle");
            if (n != 3) begin
                REQ_A = 1'b1; REQ_B = 1'b1;
            end
        end
        check("t3_q_final", {24'd0, Q}, {24'd0, Q_AFTER_T3});

        // 4. B withdraws during GRANT: no write, no ACK, back to idle.
        REQ_B = 1'b1; D_B = 8'h3C;
        @(negedge CLK);
        check("t4_gnt_b", {31'd0, GNT_B}, 32'd1);
        REQ_B = 1'b0;
        @(negedge CLK);
        check("t4_no_ack", {31'd0, ACK_B}, 32'd0);
        check("t4_busy", {31'd0, BUSY}, 32'd0);
        check("t4_q_kept", {24'd0, Q}, {24'd0, Q_AFTER_T3});

        // 5. Reset asserted during the ACK cycle clears Q and all outputs.
        REQ_A = 1'b1; D_A = 8'hFF;
        sb.push_back('{id: 1'b0, data: 8'hFF});
        wait_for(0, "t5_ack");
        RST = 1'b1; REQ_A = 1'b0;
        @(negedge CLK);
        check("t5_q", {24'd0, Q}, 32'h00);
        check("t5_outs", {27'd0, GNT_A, GNT_B, ACK_A, ACK_B, BUSY}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 6. A holds REQ in RELEASE; B must wait until A lets go.
        REQ_A = 1'b1; D_A = 8'hC3; D_B = 8'h5A;
        sb.push_back('{id: 1'b0, data: 8'hC3});
        wait_for(0, "t6_ack_a");
        REQ_B = 1'b1;
        sb.push_back('{id: 1'b1, data: 8'h5A});
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t6_gnt_b_held", {31'd0, GNT_B}, 32'd0);
            check("t6_busy_held", {31'd0, BUSY}, 32'd1);
        end
        REQ_A = 1'b0;
        wait_for(3, "t6_gnt_b");
        wait_for(1, "t6_ack_b");
        REQ_B = 1'b0;
        wait_for(2, "t6_idle");
        check("t6_q_final", {24'd0, Q}, 32'h5A);

        repeat (2) @(negedge CLK);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
